ascii_hex_word_decoder: RTL and testbench
=========================================

// Module: ascii_hex_word_decoder
// PURPOSE
// - Receive path counterpart of the nibble-to-ASCII encoder: assembles a stream of ASCII
//   hex characters (e.g. from the UART RX byte stream) into a binary word for the command
//   and register-access logic.
// - Digits are MSB-first and terminated by CR or LF. Non-hex and overflow input is
//   flagged and the line is discarded.
// - Output is a valid/ready word interface with one-word buffering.
// PARAMETERS
// - DIGITS    8      max hex digits per word; Out_Word width = 4*DIGITS
// - TERM_CR   8'h0D  first terminator character
// - TERM_LF   8'h0A  second terminator character
// PORTS
// - Clk             in   1          system clock; all logic on rising edge
// - Rst             in   1          synchronous, active-high reset
// - In_Char         in   [8:1]      ASCII character
// - In_Char_Valid   in   1          In_Char is valid this cycle
// - In_Char_Ready   out  1          decoder accepts In_Char this cycle
// - Out_Word        out  [4*DIGITS:1]  assembled value, right-justified, zero-extended
// - Out_Word_Valid  out  1          Out_Word held valid until accepted
// - Out_Word_Ready  in   1          consumer accepts Out_Word
// - Out_Digit_Cnt   out  [8:1]      digits in the presented word (1..DIGITS)
// - Out_Err         out  1          one-cycle pulse on bad char or overflow
// BEHAVIOUR
// - Char accepted iff In_Char_Valid & In_Char_Ready. In_Char_Ready = !Out_Word_Valid,
//   registered-state based, no combinational path from In_Char_Valid.
// - Hex digit map: '0'-'9' (8'h30-39) -> 0-9; 'A'-'F' (8'h41-46) -> 10-15.
//   Lowercase handling depends on macro (see CONFIGURATION).
// - States:
//   - IDLE (cnt = 0)
//     - digit: acc = nibble, cnt = 1 -> ACCUM
//     - terminator: ignored (empty line), no output
//     - other: Out_Err pulse -> DISCARD
//   - ACCUM
//     - digit with cnt < DIGITS: acc = {acc[4*DIGITS-4:1], nibble}, cnt + 1
//     - digit with cnt == DIGITS: overflow, Out_Err pulse -> DISCARD
//     - terminator: Out_Word = acc, Out_Digit_Cnt = cnt, Out_Word_Valid = 1 -> OUT
//     - other: Out_Err pulse -> DISCARD
//   - OUT
//     - In_Char_Ready = 0; hold outputs stable
//     - Out_Word_Ready = 1: Out_Word_Valid cleared next cycle, acc/cnt cleared -> IDLE
//   - DISCARD
//     - all chars dropped with no further Out_Err until a terminator -> IDLE (no word)
// - Latency: terminator accepted at cycle N -> Out_Word_Valid = 1 at N+1. Next char
//   accepted at the earliest one cycle after the handshake.
// - Out_Err is registered, high exactly one cycle after the offending char.
// - Reset values: Out_Word = 0, Out_Word_Valid = 0, Out_Digit_Cnt = 0, Out_Err = 0,
//   In_Char_Ready = 1, state IDLE. Reset mid-line or in OUT drops all data, no output.
// - Acc holds fewer than DIGITS digits in its low bits; upper bits are 0.
// CONFIGURATION
// - ASCII_HEX_DEC_LOWER_EN defined: 'a'-'f' (8'h61-66) also decode to 10-15.
// - Not defined: lowercase is a bad char -> Out_Err pulse, DISCARD.
// TESTING
// - Reset, then "1A2B\r" with DIGITS=8, Out_Word_Ready = 1 -> Out_Word = 32'h0000_1A2B,
//   Out_Digit_Cnt = 4, valid 1 cycle.
// - "DEADBEEF\n" with Out_Word_Ready = 0 for 5 cycles -> valid held 5 cycles,
//   In_Char_Ready = 0 throughout, word 32'hDEADBEEF; releases on ready.
// - "123456789\r" -> Out_Err pulse on the 9th digit, no word output; following "7\r"
//   -> word 32'h7.
// - "1G\r" -> single Out_Err after 'G', no word. "\r\n" alone -> no output, no error.
// - "ff\r": with ASCII_HEX_DEC_LOWER_EN -> word 32'hFF; without it -> Out_Err, no word.
// - Rst asserted after "AB" mid-line, then "C\r" -> word 32'hC, Out_Digit_Cnt = 1.

Source files
------------

// File: rtl/ascii_hex_word_decoder.sv
// ascii_hex_word_decoder
//   Assembles a stream of ASCII hex characters (MSB digit first, terminated by
//   CR or LF) into a right-justified binary word. The decoder flags non-hex
//   characters and digit overflow, then drops the rest of that line.
//   The output is one buffered word on a valid/ready interface.
//
// Parameters
//   DIGITS   maximum hex digits per word (>= 2); Out_Word is 4*DIGITS bits
//   TERM_CR  first line terminator character
//   TERM_LF  second line terminator character
//
// Ports
//   Clk             in   rising-edge system clock
//   Rst             in   synchronous, active-high reset
//   In_Char         in   ASCII character
//   In_Char_Valid   in   In_Char valid this cycle
//   In_Char_Ready   out  decoder accepts In_Char (low while a word is held)
//   Out_Word        out  assembled value, zero-extended
//   Out_Word_Valid  out  held high until the consumer accepts the word
//   Out_Word_Ready  in   consumer accepts Out_Word
//   Out_Digit_Cnt   out  number of digits in the presented word
//   Out_Err         out  one-cycle pulse after a bad character or overflow
//
// Configuration macro
//   ASCII_HEX_DEC_LOWER_EN  when defined, 'a'-'f' also decode as hex digits;
//                           otherwise lowercase letters are bad characters.

module ascii_hex_word_decoder #(
    parameter int         DIGITS  = 8,
    parameter logic [8:1] TERM_CR = 8'h0D,
    parameter logic [8:1] TERM_LF = 8'h0A
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [8:1]        In_Char,
    input  logic              In_Char_Valid,
    output logic              In_Char_Ready,
    output logic [4*DIGITS:1] Out_Word,
    output logic              Out_Word_Valid,
    input  logic              Out_Word_Ready,
    output logic [8:1]        Out_Digit_Cnt,
    output logic              Out_Err
);

    localparam logic [8:1] MAX_CNT = 8'(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT,
        DISCARD
    } state_t;

    state_t              state;
    logic [4*DIGITS:1]   acc;
    logic [8:1]          cnt;

    logic                accept;
    logic                is_term;
    logic                is_digit;
    logic [4:1]          nibble;

    // Ready depends only on the registered word buffer, never on In_Char_Valid.
    assign In_Char_Ready = !Out_Word_Valid;
    assign accept        = In_Char_Valid && In_Char_Ready;

    // Character classification. Letters map via their low nibble: 'A'/'a'
    // end in 1, so adding 9 yields 10.
    always_comb begin
        is_term  = (In_Char == TERM_CR) || (In_Char == TERM_LF);
        is_digit = 1'b0;
        nibble   = '0;
        if (In_Char >= 8'h30 && In_Char <= 8'h39) begin
            is_digit = 1'b1;
            nibble   = In_Char[4:1];
        end else if (In_Char >= 8'h41 && In_Char <= 8'h46) begin
            is_digit = 1'b1;
            nibble   = In_Char[4:1] + 4'd9;
        end
`ifdef ASCII_HEX_DEC_LOWER_EN
        else if (In_Char >= 8'h61 && In_Char <= 8'h66) begin
            is_digit = 1'b1;
            nibble   = In_Char[4:1] + 4'd9;
        end
`else
`endif
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state          <= IDLE;
            acc            <= '0;
            cnt            <= '0;
            Out_Word       <= '0;
            Out_Word_Valid <= 1'b0;
            Out_Digit_Cnt  <= '0;
            Out_Err        <= 1'b0;
        end else begin
            Out_Err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !is_term) begin
                        if (is_digit) begin
                            acc   <= {{(4*DIGITS-4){1'b0}}, nibble};
                            cnt   <= 8'd1;
                            state <= ACCUM;
                        end else begin
                            Out_Err <= 1'b1;
                            state   <= DISCARD;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (is_term) begin
                            Out_Word       <= acc;
                            Out_Digit_Cnt  <= cnt;
                            Out_Word_Valid <= 1'b1;
                            state          <= OUT;
                        end else if (is_digit && cnt != MAX_CNT) begin
                            acc <= {acc[4*DIGITS-4:1], nibble};
                            cnt <= cnt + 8'd1;
                        end else begin
                            // Bad character or one digit too many.
                            Out_Err <= 1'b1;
                            acc     <= '0;
                            cnt     <= '0;
                            state   <= DISCARD;
                        end
                    end
                end
                OUT: begin
                    if (Out_Word_Ready) begin
                        Out_Word_Valid <= 1'b0;
                        acc            <= '0;
                        cnt            <= '0;
                        state          <= IDLE;
                    end
                end
                DISCARD: begin
                    if (accept && is_term) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_hex_word_decoder.sv
// tb_ascii_hex_word_decoder
//   Scoreboard bench: the driver feeds characters and a line-level reference
//   model pushes expected words and error pulses (with their cycle) into
//   queues; a negedge monitor pops and compares whatever the DUT presents.

module tb_ascii_hex_word_decoder;

    localparam int         DIGITS = 8;
    localparam int         W      = 4 * DIGITS;
    localparam logic [7:0] CR     = 8'h0D;
    localparam logic [7:0] LF     = 8'h0A;

    logic          clk;
    logic          Rst;
    logic [8:1]    In_Char;
    logic          In_Char_Valid;
    logic          In_Char_Ready;
    logic [W:1]    Out_Word;
    logic          Out_Word_Valid;
    logic          Out_Word_Ready;
    logic [8:1]    Out_Digit_Cnt;
    logic          Out_Err;

    ascii_hex_word_decoder #(
        .DIGITS (DIGITS),
        .TERM_CR(8'h0D),
        .TERM_LF(8'h0A)
    ) dut (
        .Clk           (clk),
        .Rst           (Rst),
        .In_Char       (In_Char),
        .In_Char_Valid (In_Char_Valid),
        .In_Char_Ready (In_Char_Ready),
        .Out_Word      (Out_Word),
        .Out_Word_Valid(Out_Word_Valid),
        .Out_Word_Ready(Out_Word_Ready),
        .Out_Digit_Cnt (Out_Digit_Cnt),
        .Out_Err       (Out_Err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [W-1:0] word;
        int           cnt;
        int           cyc;
    } exp_t;

    exp_t wq[$];
    int   eq[$];
    int   line_digits[$];
    bit   line_bad = 0;

    function automatic int hexval(input logic [7:0] c);
        if (c >= "0" && c <= "9") return int'(c) - 48;
        if (c >= "A" && c <= "F") return int'(c) - 55;
`ifdef ASCII_HEX_DEC_LOWER_EN
        if (c >= "a" && c <= "f") return int'(c) - 87;
`else
`endif
        return -1;
    endfunction

    // acyc: cycle count at which the char's accepting edge has happened.
    task automatic model_accept(input logic [7:0] c, input int acyc);
        exp_t e;
        int   d;
        if (c == CR || c == LF) begin
            if (!line_bad && line_digits.size() > 0) begin
                e.word = '0;
                foreach (line_digits[i]) e.word = e.word * 16 + W'(line_digits[i]);
                e.cnt = line_digits.size();
                e.cyc = acyc;
                wq.push_back(e);
            end
            line_digits.delete();
            line_bad = 0;
        end else if (!line_bad) begin
            d = hexval(c);
            if (d < 0 || line_digits.size() == DIGITS) begin
                eq.push_back(acyc);
                line_bad = 1;
            end else begin
                line_digits.push_back(d);
            end
        end
    endtask

    task automatic model_reset();
        line_digits.delete();
        line_bad = 0;
        wq.delete();
        eq.delete();
    endtask

    // ---------------- consumer ready ----------------
    bit rdy_mode = 0;
    bit rdy_val  = 1;

    initial begin
        Out_Word_Ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            Out_Word_Ready = rdy_mode ? ($urandom_range(0, 2) != 0) : rdy_val;
        end
    end

    // ---------------- monitor ----------------
    bit           prev_v = 0;
    logic [W-1:0] held_word;
    exp_t         mw;
    int           me;

    always @(negedge clk) begin
        if (!Rst) begin
            check(In_Char_Ready == !Out_Word_Valid, "ready_vs_valid",
                  64'(In_Char_Ready), 64'(!Out_Word_Valid));
            if (Out_Err) begin
                if (eq.size() == 0) report_fail("unexpected_err");
                else begin
                    me = eq.pop_front();
                    check(cyc == me, "err_timing", 64'(cyc), 64'(me));
                end
            end
            while (eq.size() > 0 && eq[0] < cyc) begin
                report_fail("missing_err");
                void'(eq.pop_front());
            end
            if (Out_Word_Valid && !prev_v) begin
                if (wq.size() == 0) report_fail("unexpected_word");
                else check(cyc == wq[0].cyc, "word_latency", 64'(cyc), 64'(wq[0].cyc));
                held_word = Out_Word;
            end else if (Out_Word_Valid) begin
                check(Out_Word == held_word, "word_stable", 64'(Out_Word), 64'(held_word));
            end
            if (Out_Word_Valid && Out_Word_Ready && wq.size() > 0) begin
                mw = wq.pop_front();
                check(Out_Word == mw.word, "word_value", 64'(Out_Word), 64'(mw.word));
                check(int'(Out_Digit_Cnt) == mw.cnt, "digit_cnt",
                      64'(Out_Digit_Cnt), 64'(mw.cnt));
            end
        end
        prev_v = Out_Word_Valid;
    end

    // ---------------- driver ----------------
    bit gaps = 0;

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_char(input logic [7:0] c);
        int waited = 0;
        bit done   = 0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            In_Char_Valid = 1'b0;
            repeat ($urandom_range(1, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        In_Char       = c;
        In_Char_Valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (In_Char_Ready) begin
                model_accept(c, cyc + 1);
                done = 1;
            end else if (waited > 1000) begin
                report_fail("char_accept_timeout");
                done = 1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        In_Char_Valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(8'(s[i]));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        Rst           = 1'b1;
        In_Char_Valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        Rst = 1'b0;
        @(negedge clk);
        check(Out_Word == '0, "rst_word", 64'(Out_Word), 64'h0);
        check(Out_Word_Valid == 1'b0, "rst_valid", 64'(Out_Word_Valid), 64'h0);
        check(Out_Digit_Cnt == '0, "rst_cnt", 64'(Out_Digit_Cnt), 64'h0);
        check(Out_Err == 1'b0, "rst_err", 64'(Out_Err), 64'h0);
        check(In_Char_Ready == 1'b1, "rst_ready", 64'(In_Char_Ready), 64'h1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (!Out_Word_Valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(Out_Word_Valid == 1'b1, name, 64'(Out_Word_Valid), 64'h1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    string hex_up = "0123456789ABCDEF";
    string hex_lo = "abcdef";

    initial begin
        logic [7:0] c;
        int         len;
        Rst           = 1'b1;
        In_Char       = '0;
        In_Char_Valid = 1'b0;
        rdy_val       = 1;
        repeat (2) @(posedge clk);
        do_reset();

        // Word presented for exactly one cycle with the consumer ready.
        send_str("1A2B");
        send_char(CR);
        @(negedge clk);
        check(Out_Word_Valid == 1'b1, "1a2b_valid_on", 64'(Out_Word_Valid), 64'h1);
        @(negedge clk);
        check(Out_Word_Valid == 1'b0, "1a2b_valid_off", 64'(Out_Word_Valid), 64'h0);
        idle(2);

        // Back-pressure: word and ready held while the consumer stalls.
        rdy_val = 0;
        idle(2);
        send_str("DEADBEEF");
        send_char(LF);
        wait_valid("deadbeef_valid");
        for (int i = 0; i < 5; i++) begin
            check(Out_Word_Valid && !In_Char_Ready, "deadbeef_hold",
                  64'({Out_Word_Valid, In_Char_Ready}), 64'h2);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rdy_val = 1;
        idle(4);

        // Overflow on the 9th digit, then a clean line.
        send_str("123456789");
        send_char(CR);
        send_str("7");
        send_char(CR);
        idle(3);

        // Bad character, empty lines, lowercase.
        send_str("1G");
        send_char(CR);
        send_char(CR);
        send_char(LF);
        send_str("ff");
        send_char(CR);
        idle(3);

        // Reset mid-line drops the partial word.
        send_str("AB");
        do_reset();
        send_str("C");
        send_char(CR);
        idle(3);

        // Reset while a word is held drops it.
        rdy_val = 0;
        idle(2);
        send_str("5");
        send_char(CR);
        wait_valid("held_before_reset");
        do_reset();
        rdy_val = 1;
        send_str("FFFFFFFF");
        send_char(CR);
        idle(3);

        // Randomized lines with random consumer stalls and input gaps.
        rdy_mode = 1;
        gaps     = 1;
        for (int ln = 0; ln < 150; ln++) begin
            len = $urandom_range(0, 10);
            for (int j = 0; j < len; j++) begin
                case ($urandom_range(0, 19))
                    0: begin
                        do c = 8'($urandom_range(32, 126));
                        while (hexval(c) >= 0);
                    end
                    1, 2: c = 8'(hex_lo[$urandom_range(0, 5)]);
                    default: c = 8'(hex_up[$urandom_range(0, 15)]);
                endcase
                send_char(c);
            end
            send_char(($urandom_range(0, 1) == 0) ? CR : LF);
        end

        rdy_mode = 0;
        rdy_val  = 1;
        idle(20);
        check(wq.size() == 0, "words_outstanding", 64'(wq.size()), 64'h0);
        check(eq.size() == 0, "errs_outstanding", 64'(eq.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
